sensor_byte_streamer: RTL
=========================

Name: sensor_byte_streamer

Overview:
- Upstream feeder for the isolation-tree anomaly detector.
- Accepts full-width sensor samples from the acquisition front end and buffers them in a small circular FIFO.
- Serializes each sample into bytes, LSB first, and presents one byte per cycle as data_out/data_valid, which connect directly to the detector's data_input/data_valid.
- The sensor side cannot stall, so samples arriving while the buffer is full are dropped and recorded in a sticky overflow flag.

Parameters:
- SAMPLE_W, 16: sample width in bits; must be a multiple of 8, range 8..64.
- DEPTH, 8: FIFO depth in samples; must be a power of 2, minimum 2.
- ADDR_W, log2(DEPTH): pointer width; derived, never overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_data  input  SAMPLE_W  sensor sample.
- s_valid  input  1  sample strobe; one sample per cycle when high.
- s_ready  output  1  high when the FIFO is not full (informational; the sensor does not wait on it).
- out_en  input  1  downstream pacing enable; when low, byte emission pauses.
- data_out  output  8  serialized byte.
- data_valid  output  1  one-cycle qualifier for data_out.
- level  output  ADDR_W+1  number of samples stored in the FIFO; excludes the sample in the shift register.
- overflow  output  1  sticky flag; set when a sample is dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, reset=0) clears:
  - wr_ptr, rd_ptr, level = 0.
  - Shift register = 0, byte counter = 0, state = IDLE.
  - data_out = 0x00, data_valid = 0, overflow = 0.
  - Therefore s_ready = 1.
- Asserting reset mid-frame discards the partial sample and all stored samples; nothing is emitted afterwards until new samples are written.
- Push:
  - s_ready = (level != DEPTH), combinational from level.
  - A write occurs when s_valid && s_ready. The sample is stored at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Drop:
  - s_valid && !s_ready discards the sample and sets overflow.
  - Storage and pointers are unchanged.
- Overflow clear:
  - clear_overflow=1 clears overflow on the next edge.
  - A drop in the same cycle wins, leaving overflow=1.
- Pop:
  - Occurs only when the serializer loads; rd_ptr wraps modulo DEPTH.
  - Push and pop in the same cycle leave level unchanged.
  - A push is never accepted into a slot freed in the same cycle (no bypass when full).
- Serializer FSM, NB = SAMPLE_W/8:
  - IDLE:
    - If level != 0 and out_en=1: load the head sample into the shift register, pop, set byte counter = 0, go to SHIFT.
    - data_valid = 0.
  - SHIFT, out_en=1:
    - Register data_out = shreg[7:0] and data_valid = 1.
    - Shift shreg right by 8 and increment the byte counter.
  - SHIFT, out_en=1, emitting byte NB-1:
    - If level != 0: load the next sample and pop in the same cycle, stay in SHIFT (back-to-back, no bubble between samples).
    - Otherwise go to IDLE.
  - SHIFT, out_en=0: state, shift register and counter hold; data_valid = 0 next cycle; data_out holds its last value.
- Latency:
  - Sample written at edge N into an empty, idle block with out_en=1: loaded at edge N+1, first byte valid after edge N+2.
  - Remaining bytes follow on consecutive cycles.
- data_valid is never high for more than NB consecutive cycles per sample.
- Throughput is one byte per cycle at out_en=1. Sustained s_valid faster than once every NB cycles eventually overflows.
- Byte order is fixed: byte k = s_data[8k+7:8k], k = 0..NB-1.

Test Plan:
- Single sample:
  - Stimulus: reset release, out_en=1, write 0xA55A once.
  - Response: data_valid high for exactly 2 cycles, data_out 0x5A then 0xA5; first byte 2 cycles after the write edge; level returns to 0.
- Back-to-back samples:
  - Stimulus: write 0x1234, 0xBEEF, 0x00FF on consecutive cycles.
  - Response: bytes 34,12,EF,BE,FF,00 on 6 consecutive cycles with no bubble; overflow=0.
- Fill and overflow:
  - Stimulus: out_en=0, write 9 samples (0x0001..0x0009).
  - Response: level=8, s_ready=0, overflow=1, sample 0x0009 absent.
  - Then set out_en=1: exactly 16 bytes, 01,00,02,00,..,08,00.
- Overflow clear priority:
  - Stimulus: while full, assert clear_overflow and s_valid together.
  - Response: overflow stays 1.
  - Clear alone: overflow goes to 0 next cycle.
- Pause mid-sample:
  - Stimulus: write 0xCAFE, drop out_en for 3 cycles after the 0xFE byte.
  - Response: data_valid=0 for those 3 cycles, then 0xCA on resume; no byte lost or repeated.
- Reset mid-frame and wrap-around:
  - Stimulus: assert reset after the first byte of 0x1111 with 3 samples queued; release; write 12 samples 0x0100..0x010B at a rate of one per 2 cycles.
  - Response: after reset all outputs are 0 and no stale bytes appear; all 24 bytes are emitted in order across pointer wrap; overflow=0.

Source files
------------

// File: rtl/sensor_byte_streamer.sv
// sensor_byte_streamer
//   Buffers full-width sensor samples in a small circular FIFO and serializes
//   each one into bytes (LSB first), one byte per cycle, for the isolation-tree
//   anomaly detector. The sensor cannot stall, so a sample that arrives while
//   the FIFO is full is dropped and latched into a sticky overflow flag.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   s_data         sensor sample (SAMPLE_W bits)
//   s_valid        sample strobe, at most one sample per cycle
//   s_ready        FIFO not full (informational, the sensor does not wait)
//   out_en         downstream pacing enable; low pauses byte emission
//   data_out       serialized byte
//   data_valid     one-cycle qualifier for data_out
//   level          samples held in the FIFO (not counting the one being shifted)
//   overflow       sticky drop flag
//   clear_overflow synchronous clear of overflow (a same-cycle drop wins)
module sensor_byte_streamer #(
  parameter  int SAMPLE_W = 16,
  parameter  int DEPTH    = 8,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                out_en,
  output logic [7:0]          data_out,
  output logic                data_valid,
  output logic [ADDR_W:0]     level,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int NB    = SAMPLE_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [ADDR_W:0]  FULL_LVL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [SAMPLE_W-1:0] shreg_p0;
  logic [CNT_W-1:0]    byte_cnt;
  logic [0:0]          state;

  logic push;
  logic drop;
  logic pop;
  logic emit;
  logic last_byte;

  // s_ready comes from the registered level, so a slot freed by a pop this
  // cycle is never reused by a push in the same cycle.
  assign s_ready   = (level != FULL_LVL);
  assign push      = s_valid && s_ready;
  assign drop      = s_valid && !s_ready;
  assign emit      = (state == SHIFT) && out_en;
  assign last_byte = (byte_cnt == LAST_BYTE);
  // A pop is the serializer loading: from IDLE, or chained onto the last byte
  // of the current sample so consecutive samples leave no bubble.
  assign pop       = out_en && (level != '0) && ((state == IDLE) || last_byte);

  // ---- stage: FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // ---- stage: FIFO control ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---- stage: serializer (shift register -> byte output) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg_p0   <= '0;
      byte_cnt   <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
    end else begin
      data_valid <= emit;
      if (emit) begin
        data_out <= shreg_p0[7:0];
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            shreg_p0 <= mem[rd_ptr];
            byte_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_en) begin
            if (last_byte) begin
              if (pop) begin
                shreg_p0 <= mem[rd_ptr];
                byte_cnt <= '0;
              end else begin
                shreg_p0 <= shreg_p0 >> 8;
                byte_cnt <= '0;
                state    <= IDLE;
              end
            end else begin
              shreg_p0 <= shreg_p0 >> 8;
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
